// File: rtl/muldiv_hilo_unit.sv
// muldiv_hilo_unit: iterative multiply/divide unit with integrated HI/LO pair.
// MULTU/MULT use shift-add, DIVU/DIV use restoring shift-subtract, one bit per
// cycle. MTHI/MTLO write HI/LO directly from IDLE.
// Optional macro MULDIV_EARLY_OUT_EN: multiply leaves RUN once the remaining
// multiplier bits are all zero, and the accumulator is realigned in FIX.
module muldiv_hilo_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cancel,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } state_t;

    localparam logic [2:0] OP_MULTU = 3'b000;
    localparam logic [2:0] OP_MULT  = 3'b001;
    localparam logic [2:0] OP_DIVU  = 3'b010;
    localparam logic [2:0] OP_DIV   = 3'b011;
    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;

    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic [WIDTH-1:0]     opnd_q, opnd_d;
    logic                 is_div_q, is_div_d;
    logic                 neg_q, neg_d;
    logic                 rem_neg_q, rem_neg_d;
    logic [WIDTH-1:0]     hi_q, hi_d;
    logic [WIDTH-1:0]     lo_q, lo_d;
    logic                 done_q, done_d;
`ifdef MULDIV_EARLY_OUT_EN
    logic [WIDTH-1:0]     mpl_q, mpl_d;
`endif

    logic                 sgn_a, sgn_b;
    logic [WIDTH-1:0]     mag_a, mag_b;
    logic [WIDTH:0]       sum_w;
    logic [WIDTH:0]       trial_w;
    logic [2*WIDTH-1:0]   fix_acc;
    logic [2*WIDTH-1:0]   prod_w;
    logic [WIDTH-1:0]     rem_w;

    // Next-state, datapath iteration and HI/LO write logic for the IDLE/RUN/FIX sequence
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        opnd_d    = opnd_q;
        is_div_d  = is_div_q;
        neg_d     = neg_q;
        rem_neg_d = rem_neg_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        done_d    = 1'b0;
`ifdef MULDIV_EARLY_OUT_EN
        mpl_d     = mpl_q;
`endif
        sgn_a     = op[0] & a[WIDTH-1];
        sgn_b     = op[0] & b[WIDTH-1];
        mag_a     = sgn_a ? -a : a;
        mag_b     = sgn_b ? -b : b;
        sum_w     = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
        trial_w   = acc_q[2*WIDTH-1:WIDTH-1] - {1'b0, opnd_q};
        fix_acc   = acc_q;
`ifdef MULDIV_EARLY_OUT_EN
        if (!is_div_q) begin
            fix_acc = acc_q >> (CNT_W'(WIDTH) - cnt_q);
        end
`endif
        prod_w    = neg_q ? -fix_acc : fix_acc;
        rem_w     = fix_acc[2*WIDTH-1:WIDTH];

        case (state_q)
            IDLE: begin
                if (start) begin
                    case (op)
                        OP_MULTU, OP_MULT: begin
                            acc_d     = {{WIDTH{1'b0}}, mag_b};
                            opnd_d    = mag_a;
                            is_div_d  = 1'b0;
                            neg_d     = sgn_a ^ sgn_b;
                            rem_neg_d = 1'b0;
`ifdef MULDIV_EARLY_OUT_EN
                            mpl_d     = mag_b;
`endif
                            cnt_d     = '0;
                            state_d   = RUN;
                        end
                        OP_DIVU, OP_DIV: begin
                            // With a zero divisor the restoring loop yields an
                            // all-ones quotient and |a| as remainder, so clearing
                            // the quotient sign and keeping the dividend sign on
                            // the remainder gives lo=all ones, hi=a directly.
                            acc_d     = {{WIDTH{1'b0}}, mag_a};
                            opnd_d    = mag_b;
                            is_div_d  = 1'b1;
                            neg_d     = (b == '0) ? 1'b0 : (sgn_a ^ sgn_b);
                            rem_neg_d = sgn_a;
                            cnt_d     = '0;
                            state_d   = RUN;
                        end
                        OP_MTHI: hi_d = a;
                        OP_MTLO: lo_d = a;
                        default: ;
                    endcase
                end
            end
            RUN: begin
                if (cancel) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                    if (is_div_q) begin
                        if (!trial_w[WIDTH]) begin
                            acc_d = {trial_w[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
                        end else begin
                            acc_d = {acc_q[2*WIDTH-2:0], 1'b0};
                        end
                    end else begin
                        acc_d = {sum_w, acc_q[WIDTH-1:1]};
                    end
`ifdef MULDIV_EARLY_OUT_EN
                    mpl_d = mpl_q >> 1;
                    if (cnt_q == LAST_ITER || (!is_div_q && mpl_q[WIDTH-1:1] == '0)) begin
                        state_d = FIX;
                    end
`else
                    if (cnt_q == LAST_ITER) begin
                        state_d = FIX;
                    end
`endif
                end
            end
            FIX: begin
                if (is_div_q) begin
                    lo_d = neg_q ? -fix_acc[WIDTH-1:0] : fix_acc[WIDTH-1:0];
                    hi_d = rem_neg_q ? -rem_w : rem_w;
                end else begin
                    {hi_d, lo_d} = prod_w;
                end
                done_d  = 1'b1;
                cnt_d   = '0;
                state_d = IDLE;
            end
            default: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            acc_q     <= '0;
            opnd_q    <= '0;
            is_div_q  <= 1'b0;
            neg_q     <= 1'b0;
            rem_neg_q <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
            done_q    <= 1'b0;
`ifdef MULDIV_EARLY_OUT_EN
            mpl_q     <= '0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            opnd_q    <= opnd_d;
            is_div_q  <= is_div_d;
            neg_q     <= neg_d;
            rem_neg_q <= rem_neg_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            done_q    <= done_d;
`ifdef MULDIV_EARLY_OUT_EN
            mpl_q     <= mpl_d;
`endif
        end
    end

    assign busy = (state_q != IDLE);
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_muldiv_hilo_unit.sv
// tb_muldiv_hilo_unit: directed and randomized checks of muldiv_hilo_unit
// against an arithmetic reference of MULTU/MULT/DIVU/DIV and MTHI/MTLO.
module tb_muldiv_hilo_unit;

    localparam int WIDTH = 32;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [2:0]        op;
    logic [WIDTH-1:0]  a;
    logic [WIDTH-1:0]  b;
    logic              cancel;
    logic              busy;
    logic              done;
    logic [WIDTH-1:0]  hi;
    logic [WIDTH-1:0]  lo;

    int                vectors = 0;
    int                miscompares = 0;
    logic [WIDTH-1:0]  mhi = '0;
    logic [WIDTH-1:0]  mlo = '0;

    muldiv_hilo_unit #(.WIDTH(WIDTH), .CNT_W(6)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .op     (op),
        .a      (a),
        .b      (b),
        .cancel (cancel),
        .busy   (busy),
        .done   (done),
        .hi     (hi),
        .lo     (lo)
    );

    // Free-running clock
    always #5 clk = ~clk;

    // Single comparison point: counts every check and reports mismatches
    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one rising edge and settle
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference {hi,lo} from plain arithmetic
    function automatic logic [63:0] refResult(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        longint       sx, sy, q, r;
        logic [63:0]  res;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        case (o)
            3'd0: res = {32'd0, x} * {32'd0, y};
            3'd1: res = sx * sy;
            3'd2: begin
                if (y == 0) res = {x, 32'hFFFFFFFF};
                else        res = {x % y, x / y};
            end
            default: begin
                if (y == 0) begin
                    res = {x, 32'hFFFFFFFF};
                end else begin
                    q   = sx / sy;
                    r   = sx % sy;
                    res = {r[31:0], q[31:0]};
                end
            end
        endcase
        return res;
    endfunction

    // Issue one op and follow it to completion, checking hold, latency and result
    task automatic applyStimulus(input logic [2:0] opIn, input logic [31:0] aIn, input logic [31:0] bIn,
                                 input bit intrude, input bit cancelAtIssue, input bit cancelAtFix,
                                 output int latOut);
        logic [63:0] expv;
        int          edges;
        op     = opIn;
        a      = aIn;
        b      = bIn;
        start  = 1'b1;
        cancel = cancelAtIssue;
        tick();
        start  = 1'b0;
        cancel = 1'b0;
        a      = $urandom;
        b      = $urandom;
        edges  = 0;
        latOut = 0;
        if (opIn == 3'd4) mhi = aIn;
        if (opIn == 3'd5) mlo = aIn;
        if (opIn > 3'd3) begin
            checkOutput("idle_busy", 64'(busy), 64'd0);
            checkOutput("idle_done", 64'(done), 64'd0);
            checkOutput("idle_hi", 64'(hi), 64'(mhi));
            checkOutput("idle_lo", 64'(lo), 64'(mlo));
            return;
        end
        expv = refResult(opIn, aIn, bIn);
        while (done !== 1'b1 && edges < 40) begin
            checkOutput("run_busy", 64'(busy), 64'd1);
            checkOutput("run_hi_hold", 64'(hi), 64'(mhi));
            checkOutput("run_lo_hold", 64'(lo), 64'(mlo));
            if (intrude && edges == 3) begin
                start = 1'b1;
                op    = 3'd4;
            end
            if (cancelAtFix && edges == WIDTH) cancel = 1'b1;
            tick();
            edges++;
            start  = 1'b0;
            cancel = 1'b0;
            op     = opIn;
        end
        latOut = edges;
        checkOutput("done_pulse", 64'(done), 64'd1);
`ifdef MULDIV_EARLY_OUT_EN
        if (opIn[1]) checkOutput("latency", 64'(edges), 64'd33);
        else         checkOutput("latency_range", 64'(edges >= 2 && edges <= 33), 64'd1);
`else
        checkOutput("latency", 64'(edges), 64'd33);
`endif
        checkOutput("done_busy", 64'(busy), 64'd0);
        mhi = expv[63:32];
        mlo = expv[31:0];
        checkOutput("result_hi", 64'(hi), 64'(mhi));
        checkOutput("result_lo", 64'(lo), 64'(mlo));
        tick();
        checkOutput("done_one_cycle", 64'(done), 64'd0);
    endtask

    // Start a long MULTU then abort it by cancel or reset at a given edge
    task automatic abortRun(input bit useReset, input int atEdge);
        bit sawDone;
        op    = 3'd0;
        a     = $urandom;
        b     = $urandom | 32'h80000000;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (atEdge - 1) tick();
        if (useReset) rst = 1'b1;
        else          cancel = 1'b1;
        tick();
        rst    = 1'b0;
        cancel = 1'b0;
        if (useReset) begin
            mhi = '0;
            mlo = '0;
        end
        checkOutput(useReset ? "rst_busy" : "cancel_busy", 64'(busy), 64'd0);
        checkOutput(useReset ? "rst_done" : "cancel_done", 64'(done), 64'd0);
        checkOutput(useReset ? "rst_hi" : "cancel_hi", 64'(hi), 64'(mhi));
        checkOutput(useReset ? "rst_lo" : "cancel_lo", 64'(lo), 64'(mlo));
        sawDone = 1'b0;
        repeat (40) begin
            tick();
            if (done === 1'b1) sawDone = 1'b1;
        end
        checkOutput("no_late_done", 64'(sawDone), 64'd0);
    endtask

    // Directed test plan followed by randomized ops
    initial begin
        int          lat;
        int          sel;
        logic [2:0]  rop;
        logic [31:0] ra, rb;
        rst    = 1'b1;
        start  = 1'b0;
        cancel = 1'b0;
        op     = 3'd0;
        a      = '0;
        b      = '0;
        tick();
        tick();
        checkOutput("reset_busy", 64'(busy), 64'd0);
        checkOutput("reset_done", 64'(done), 64'd0);
        checkOutput("reset_hi", 64'(hi), 64'd0);
        checkOutput("reset_lo", 64'(lo), 64'd0);
        rst = 1'b0;
        tick();

        applyStimulus(3'd4, 32'h00001234, 32'd0, 1'b0, 1'b0, 1'b0, lat);
        applyStimulus(3'd5, 32'h00005678, 32'd0, 1'b0, 1'b0, 1'b0, lat);
        abortRun(1'b1, 5);
        applyStimulus(3'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0, lat);
        applyStimulus(3'd1, 32'hFFFFFFF9, 32'd3, 1'b0, 1'b0, 1'b0, lat);
        applyStimulus(3'd3, 32'hFFFFFFF9, 32'd2, 1'b0, 1'b0, 1'b0, lat);
        applyStimulus(3'd2, 32'd100, 32'd0, 1'b0, 1'b0, 1'b0, lat);
        applyStimulus(3'd3, 32'hFFFFFF9C, 32'd0, 1'b0, 1'b0, 1'b0, lat);
        applyStimulus(3'd3, 32'h80000000, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0, lat);
        abortRun(1'b0, 10);
        applyStimulus(3'd0, 32'h0000ABCD, 32'h80001234, 1'b1, 1'b0, 1'b0, lat);
        applyStimulus(3'd2, 32'hDEADBEEF, 32'h00000013, 1'b0, 1'b1, 1'b0, lat);
        applyStimulus(3'd2, 32'h12345678, 32'h00000100, 1'b0, 1'b0, 1'b1, lat);
        applyStimulus(3'd6, 32'hCAFEF00D, 32'd1, 1'b0, 1'b0, 1'b0, lat);
        applyStimulus(3'd7, 32'hCAFEF00D, 32'd1, 1'b0, 1'b0, 1'b0, lat);
        cancel = 1'b1;
        tick();
        cancel = 1'b0;
        checkOutput("idle_cancel_busy", 64'(busy), 64'd0);
        checkOutput("idle_cancel_hi", 64'(hi), 64'(mhi));
`ifdef MULDIV_EARLY_OUT_EN
        applyStimulus(3'd0, 32'd5, 32'd1, 1'b0, 1'b0, 1'b0, lat);
        checkOutput("early_out_latency", 64'(lat <= 2), 64'd1);
`endif

        for (int i = 0; i < 30; i++) begin
            sel = $urandom_range(0, 5);
            rop = 3'($urandom_range(0, 3));
            ra  = $urandom;
            rb  = $urandom;
            case (sel)
                0: rb = '0;
                1: begin ra = 32'h80000000; rb = 32'hFFFFFFFF; end
                2: begin
                    ra = $urandom_range(0, 20);
                    rb = $urandom_range(1, 9);
                    if ($urandom_range(0, 1) == 1) ra = -ra;
                    if ($urandom_range(0, 1) == 1) rb = -rb;
                end
                default: ;
            endcase
            if ($urandom_range(0, 7) == 0) rop = 3'd4 + 3'($urandom_range(0, 1));
            applyStimulus(rop, ra, rb, 1'b0, 1'b0, 1'b0, lat);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
